bus_ctrl: RTL and testbench

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/vm8088_pkg.sv | 12 +
 rtl/bus_ctrl.sv | 138 +++++++++++++
 tb/tb_bus_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vm8088_pkg.sv
// Shared definitions for the vm8088 bus controller: FSM encoding and default timeout.
package vm8088_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_ctrl.sv
// Core-to-memory bus controller: one memory transaction per core_locked pulse,
// with a single-entry read/write cache and a sticky timeout error flag.
module bus_ctrl
  import vm8088_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] core_address,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  output logic [7:0]  core_in,
  output logic        core_locked,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  bus_state_e  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  coreIn_q, coreIn_d;
  logic        coreLocked_q, coreLocked_d;
  logic [19:0] memAddr_q, memAddr_d;
  logic [7:0]  memWdata_q, memWdata_d;
  logic        memWe_q, memWe_d;
  logic        memReq_q, memReq_d;
  logic        busError_q, busError_d;
  logic [19:0] cacheAddr_q, cacheAddr_d;
  logic [7:0]  cacheData_q, cacheData_d;
  logic        cacheValid_q, cacheValid_d;

  logic readHit;

  assign readHit = cacheValid_q && !core_we && (core_address == cacheAddr_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    coreIn_d     = coreIn_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    memWe_d      = memWe_q;
    memReq_d     = memReq_q;
    busError_d   = busError_q;
    cacheAddr_d  = cacheAddr_q;
    cacheData_d  = cacheData_q;
    cacheValid_d = cacheValid_q;

    unique case (state_q)
      IDLE: begin
        if (readHit) begin
          coreIn_d = cacheData_q;
          state_d  = DONE;
        end else begin
          memAddr_d  = core_address;
          memWdata_d = core_out;
          memWe_d    = core_we;
          memReq_d   = 1'b1;
          count_d    = 8'd0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack) begin
          memReq_d     = 1'b0;
          cacheAddr_d  = memAddr_q;
          cacheValid_d = 1'b1;
          if (memWe_q) begin
            cacheData_d = memWdata_q;
          end else begin
            cacheData_d = mem_rdata;
            coreIn_d    = mem_rdata;
          end
          state_d = DONE;
        end else if (count_q == TimeoutLast) begin
          memReq_d     = 1'b0;
          coreIn_d     = 8'hFF;
          busError_d   = 1'b1;
          cacheValid_d = 1'b0;
          state_d      = DONE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    coreLocked_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      coreIn_q     <= 8'h00;
      coreLocked_q <= 1'b0;
      memAddr_q    <= 20'h0;
      memWdata_q   <= 8'h00;
      memWe_q      <= 1'b0;
      memReq_q     <= 1'b0;
      busError_q   <= 1'b0;
      cacheAddr_q  <= 20'h0;
      cacheData_q  <= 8'h00;
      cacheValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      coreIn_q     <= coreIn_d;
      coreLocked_q <= coreLocked_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      memWe_q      <= memWe_d;
      memReq_q     <= memReq_d;
      busError_q   <= busError_d;
      cacheAddr_q  <= cacheAddr_d;
      cacheData_q  <= cacheData_d;
      cacheValid_q <= cacheValid_d;
    end
  end

  assign core_in     = coreIn_q;
  assign core_locked = coreLocked_q;
  assign mem_address = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign mem_we      = memWe_q;
  assign mem_req     = memReq_q;
  assign bus_error   = busError_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed scoreboard bench for bus_ctrl: a small core/memory model predicts
// each transaction's data, latency, request length and error flag.
module tb_bus_ctrl;

  localparam int Timeout = 4;

  typedef struct {
    logic [7:0] data;
    int         latency;
    int         reqCycles;
    logic       err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] core_address;
  logic [7:0]  core_out;
  logic        core_we;
  logic [7:0]  core_in;
  logic        core_locked;
  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic        mValid;
  logic [19:0] mAddr;
  logic [7:0]  mData;
  logic [7:0]  mCoreIn;
  logic        mErr;

  bus_ctrl #(.TIMEOUT(Timeout)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .core_address(core_address),
    .core_out    (core_out),
    .core_we     (core_we),
    .core_in     (core_in),
    .core_locked (core_locked),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .bus_error   (bus_error)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mValid  = 1'b0;
    mAddr   = 20'h0;
    mData   = 8'h00;
    mCoreIn = 8'h00;
    mErr    = 1'b0;
  endtask

  // Pops the oldest prediction and compares it with what the DUT delivered.
  task automatic checkOutput(input int latency, input int reqCycles);
    exp_t e;
    checkValue("sb_pending", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue("core_in", 32'(core_in), 32'(e.data));
      checkValue("latency", 32'(latency), 32'(e.latency));
      checkValue("req_cycles", 32'(reqCycles), 32'(e.reqCycles));
      checkValue("bus_error", 32'(bus_error), 32'(e.err));
    end
  endtask

  // Called during an IDLE cycle; drives one core access and plays the memory side.
  task automatic applyStimulus(input logic [19:0] addr, input logic we, input logic [7:0] wdata,
                               input int ackCycle, input logic [7:0] rdata);
    exp_t e;
    int   cycles;
    int   reqCycles;
    bit   done;
    core_address = addr;
    core_we      = we;
    core_out     = wdata;

    if (mValid && !we && addr == mAddr) begin
      mCoreIn     = mData;
      e.latency   = 1;
      e.reqCycles = 0;
    end else if (ackCycle >= 1 && ackCycle <= Timeout) begin
      if (!we) mCoreIn = rdata;
      mValid      = 1'b1;
      mAddr       = addr;
      mData       = we ? wdata : rdata;
      e.latency   = ackCycle + 1;
      e.reqCycles = ackCycle;
    end else begin
      mCoreIn     = 8'hFF;
      mErr        = 1'b1;
      mValid      = 1'b0;
      e.latency   = Timeout + 1;
      e.reqCycles = Timeout;
    end
    e.data = mCoreIn;
    e.err  = mErr;
    sb.push_back(e);

    cycles    = 0;
    reqCycles = 0;
    done      = 0;
    while (!done && cycles < 300) begin
      @(posedge clock);
      #1;
      cycles++;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (core_locked) begin
        done = 1;
        checkOutput(cycles, reqCycles);
      end else if (mem_req) begin
        reqCycles++;
        checkValue("mem_address", 32'(mem_address), 32'(addr));
        checkValue("mem_we", 32'(mem_we), 32'(we));
        if (we) checkValue("mem_wdata", 32'(mem_wdata), 32'(wdata));
        core_address = ~addr;
        core_we      = ~we;
        core_out     = ~wdata;
        if (reqCycles == ackCycle) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    checkValue("core_locked_seen", 32'(done), 32'd1);
    if (!done) begin
      if (sb.size() > 0) sb.delete(0);
    end else begin
      @(posedge clock);
      #1;
      checkValue("locked_single_pulse", 32'(core_locked), 32'd0);
      checkValue("idle_no_req", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    core_address = 20'hFFFF0;
    core_out     = 8'h00;
    core_we      = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = 8'h00;
    modelReset();
    #12;
    checkValue("rst_core_in", 32'(core_in), 32'h00);
    checkValue("rst_core_locked", 32'(core_locked), 32'd0);
    checkValue("rst_mem_req", 32'(mem_req), 32'd0);
    checkValue("rst_mem_we", 32'(mem_we), 32'd0);
    checkValue("rst_mem_address", 32'(mem_address), 32'h0);
    checkValue("rst_mem_wdata", 32'(mem_wdata), 32'h00);
    checkValue("rst_bus_error", 32'(bus_error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] read miss / hit of reset vector");
    applyStimulus(20'hFFFF0, 1'b0, 8'h00, 3, 8'hEA);
    applyStimulus(20'hFFFF0, 1'b0, 8'h00, 0, 8'h00);

    $display("[TB] write then read from cache");
    applyStimulus(20'h00400, 1'b1, 8'h5A, 1, 8'h00);
    applyStimulus(20'h00400, 1'b0, 8'h00, 0, 8'h00);
    applyStimulus(20'hFFFF0, 1'b0, 8'h00, 2, 8'h11);

    $display("[TB] ack coincident with final timeout cycle");
    applyStimulus(20'hFFFFF, 1'b1, 8'hC3, Timeout, 8'h00);
    applyStimulus(20'hFFFFF, 1'b0, 8'h00, 0, 8'h00);
    applyStimulus(20'h00001, 1'b0, 8'h00, Timeout, 8'h77);

    $display("[TB] timeout and sticky error");
    applyStimulus(20'h00002, 1'b0, 8'h00, 0, 8'h00);
    applyStimulus(20'h00001, 1'b0, 8'h00, 1, 8'h42);

    $display("[TB] reset in the middle of a request");
    core_address = 20'h12345;
    core_we      = 1'b0;
    @(posedge clock);
    #1;
    checkValue("midreq_req_up", 32'(mem_req), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkValue("midreq_mem_req", 32'(mem_req), 32'd0);
    checkValue("midreq_core_locked", 32'(core_locked), 32'd0);
    checkValue("midreq_bus_error", 32'(bus_error), 32'd0);
    checkValue("midreq_core_in", 32'(core_in), 32'h00);
    checkValue("midreq_mem_address", 32'(mem_address), 32'h0);
    modelReset();
    core_address = 20'hFFFF0;
    @(posedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    applyStimulus(20'hFFFF0, 1'b0, 8'h00, 2, 8'h3C);
    applyStimulus(20'hFFFF0, 1'b0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
